// File: rtl/onchip_memory_loader.sv
// Avalon-MM write master: packs a little-endian byte stream into 32-bit words of on-chip memory.
// Optional read-back verify is built when ONCHIP_MEMORY_LOADER_VERIFY_EN is defined.
module onchip_memory_loader #(
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 8192,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       len_bytes,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_VERIFY_RD, S_VERIFY_CMP, S_DONE
  } state_t;

  localparam logic [31:0]       MAX_BYTES = 32'((DEPTH - BASE_ADDR) * 4);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [15:0]       checksum_q, checksum_d, rem_q, rem_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, address_q, address_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic              chipselect_q, chipselect_d, write_q, write_d;
  logic [31:0]       writedata_q, writedata_d, word_q, word_d, packed_s;
  logic [1:0]        lane_q, lane_d;
  logic [3:0]        be_s;

`ifdef ONCHIP_MEMORY_LOADER_VERIFY_EN
  logic [15:0]       vsum_q, vsum_d, vsum_s;
  logic [3:0]        last_be_q, last_be_d;
  logic [ADDR_W-1:0] last_addr_s;

  function automatic logic [15:0] lane_sum(input logic [31:0] w, input logic [3:0] be);
    logic [15:0] s;
    s = 16'd0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) s = s + {8'd0, w[8*i +: 8]};
      else       s = s;
    end
    return s;
  endfunction
`else
  logic unused_readdata_s;
  assign unused_readdata_s = ^readdata;
`endif

  assign clken = 1'b1;

  // Next-state and next-output computation for the load/verify sequencer.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    checksum_d   = checksum_q;
    rem_d        = rem_q;
    ptr_d        = ptr_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    chipselect_d = chipselect_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    word_d       = word_q;
    lane_d       = lane_q;
    packed_s     = word_q | ({24'd0, in_data} << {lane_q, 3'b000});
    case (lane_q)
      2'd0:    be_s = 4'h1;
      2'd1:    be_s = 4'h3;
      2'd2:    be_s = 4'h7;
      2'd3:    be_s = 4'hF;
      default: be_s = 4'hF;
    endcase
`ifdef ONCHIP_MEMORY_LOADER_VERIFY_EN
    vsum_d      = vsum_q;
    last_be_d   = last_be_q;
    last_addr_s = ptr_q - ADDR_W'(1);
    vsum_s      = vsum_q + lane_sum(readdata, byteenable_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          checksum_d = 16'd0;
          if (len_bytes == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if ({16'd0, len_bytes} > MAX_BYTES) begin
            error_d = 1'b1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            busy_d     = 1'b1;
            rem_d      = len_bytes;
            ptr_d      = BASE;
            lane_d     = 2'd0;
            word_d     = 32'd0;
            in_ready_d = 1'b1;
            state_d    = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          checksum_d = checksum_q + {8'd0, in_data};
          rem_d      = rem_q - 16'd1;
          // A word is flushed when full or when the image ends mid-word.
          if (lane_q == 2'd3 || rem_q == 16'd1) begin
            address_d    = ptr_q;
            writedata_d  = packed_s;
            byteenable_d = be_s;
            chipselect_d = 1'b1;
            write_d      = 1'b1;
            word_d       = 32'd0;
            lane_d       = 2'd0;
            in_ready_d   = 1'b0;
            state_d      = S_WRITE;
`ifdef ONCHIP_MEMORY_LOADER_VERIFY_EN
            last_be_d    = be_s;
`endif
          end else begin
            word_d = packed_s;
            lane_d = lane_q + 2'd1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        chipselect_d = 1'b0;
        write_d      = 1'b0;
        ptr_d        = ptr_q + ADDR_W'(1);
        if (rem_q != 16'd0) begin
          in_ready_d = 1'b1;
          state_d    = S_LOAD;
        end else begin
`ifdef ONCHIP_MEMORY_LOADER_VERIFY_EN
          address_d    = BASE;
          byteenable_d = (BASE == ptr_q) ? last_be_q : 4'hF;
          chipselect_d = 1'b1;
          vsum_d       = 16'd0;
          state_d      = S_VERIFY_RD;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end
      end
`ifdef ONCHIP_MEMORY_LOADER_VERIFY_EN
      S_VERIFY_RD: begin
        chipselect_d = 1'b0;
        state_d      = S_VERIFY_CMP;
      end
      S_VERIFY_CMP: begin
        // ptr_q already points one past the last written word here.
        if (address_q == last_addr_s) begin
          error_d = (vsum_s != checksum_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          vsum_d       = vsum_s;
          address_d    = address_q + ADDR_W'(1);
          byteenable_d = ((address_q + ADDR_W'(1)) == last_addr_s) ? last_be_q : 4'hF;
          chipselect_d = 1'b1;
          state_d      = S_VERIFY_RD;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        in_ready_d   = 1'b0;
        chipselect_d = 1'b0;
        write_d      = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      checksum_q   <= 16'd0;
      rem_q        <= 16'd0;
      ptr_q        <= '0;
      address_q    <= '0;
      byteenable_q <= 4'h0;
      chipselect_q <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 32'd0;
      word_q       <= 32'd0;
      lane_q       <= 2'd0;
`ifdef ONCHIP_MEMORY_LOADER_VERIFY_EN
      vsum_q       <= 16'd0;
      last_be_q    <= 4'h0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      checksum_q   <= checksum_d;
      rem_q        <= rem_d;
      ptr_q        <= ptr_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      chipselect_q <= chipselect_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
`ifdef ONCHIP_MEMORY_LOADER_VERIFY_EN
      vsum_q       <= vsum_d;
      last_be_q    <= last_be_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign checksum   = checksum_q;
  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign chipselect = chipselect_q;
  assign write      = write_q;
  assign writedata  = writedata_q;

endmodule

// File: tb/tb_onchip_memory_loader.sv
// Scoreboard bench for onchip_memory_loader: expected writes and done status are queued
// by the stimulus and popped by a negedge monitor.
module tb_onchip_memory_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len_bytes = 16'd0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, busy, done, error, chipselect, write, clken;
  logic [15:0] checksum;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  onchip_memory_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len_bytes(len_bytes),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .done(done), .error(error), .checksum(checksum), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .writedata(writedata), .clken(clken), .readdata(readdata)
  );

  typedef struct packed {
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_wr[$];
  logic [16:0] exp_done[$];
  int          tests = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic        flip = 1'b0;
  logic [31:0] mem [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: byte-enabled write, one-cycle read latency, optional bit flip on word 1.
  always @(posedge clk) begin
    if (chipselect && write) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[address[3:0]][8*i +: 8] <= writedata[8*i +: 8];
    end
    readdata <= mem[address[3:0]] ^ ((flip && address == 13'd1) ? 32'd1 : 32'd0);
  end

  // Monitor: compare every write and every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (chipselect && write) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", address, writedata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", {19'd0, address}, {19'd0, e.a});
          check("wr_data", writedata, e.d);
          check("wr_be", {28'd0, byteenable}, {28'd0, e.be});
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          logic [16:0] e;
          e = exp_done.pop_front();
          check("checksum", {16'd0, checksum}, {16'd0, e[15:0]});
          check("error", {31'd0, error}, {31'd0, e[16]});
          check("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] len);
    @(negedge clk); start = 1'b1; len_bytes = len;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap, input bit pulse);
    int n;
    if (gap) begin
      @(negedge clk); in_valid = 1'b0; start = pulse;
      if (pulse) len_bytes = 16'd3;
      @(negedge clk); start = 1'b0;
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 50 cycles");
    end
  endtask

  task automatic end_stream();
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check("done_count", done_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_cs"}, {31'd0, chipselect}, 32'd0);
    check({tag, "_write"}, {31'd0, write}, 32'd0);
    check({tag, "_checksum"}, {16'd0, checksum}, 32'd0);
    check({tag, "_address"}, {19'd0, address}, 32'd0);
    check({tag, "_be"}, {28'd0, byteenable}, 32'd0);
    check({tag, "_wdata"}, writedata, 32'd0);
    check({tag, "_clken"}, {31'd0, clken}, 32'd1);
  endtask

  initial begin
    int w0;
    int d0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); reset_n = 1'b1;

    // Eight bytes 01..08 into two full words.
    exp_wr.push_back({13'd0, 32'h04030201, 4'hF});
    exp_wr.push_back({13'd1, 32'h08070605, 4'hF});
    exp_done.push_back({1'b0, 16'h0024});
    w0 = wr_cnt;
    do_start(16'd8);
    for (int k = 1; k <= 8; k++) send(8'(k), 1'b0, 1'b0);
    end_stream();
    wait_done(1);
    check("len8_writes", wr_cnt - w0, 2);

    // Five bytes: final partial word with one lane.
    exp_wr.push_back({13'd0, 32'h44332211, 4'hF});
    exp_wr.push_back({13'd1, 32'h00000055, 4'h1});
    exp_done.push_back({1'b0, 16'h00FF});
    w0 = wr_cnt;
    do_start(16'd5);
    for (int k = 1; k <= 5; k++) send(8'(8'h11 * k), 1'b0, 1'b0);
    end_stream();
    wait_done(2);
    check("len5_writes", wr_cnt - w0, 2);
    check("mem_word1", mem[1], 32'h08070655);

    // Zero length: done only.
    exp_done.push_back({1'b0, 16'h0000});
    w0 = wr_cnt;
    do_start(16'd0);
    wait_done(3);
    check("len0_writes", wr_cnt - w0, 0);

    // Over-length image rejected.
    exp_done.push_back({1'b1, 16'h0000});
    w0 = wr_cnt;
    do_start(16'd32769);
    wait_done(4);
    check("overflow_writes", wr_cnt - w0, 0);

    // Throttled stream with a start pulse mid-load that must be ignored.
    exp_wr.push_back({13'd0, 32'h04030201, 4'hF});
    exp_wr.push_back({13'd1, 32'h08070605, 4'hF});
    exp_done.push_back({1'b0, 16'h0024});
    w0 = wr_cnt;
    do_start(16'd8);
    for (int k = 1; k <= 8; k++) send(8'(k), 1'b1, k == 3);
    end_stream();
    wait_done(5);
    check("gap_writes", wr_cnt - w0, 2);
    repeat (5) @(negedge clk);
    check("gap_single_done", done_cnt, 5);

`ifdef ONCHIP_MEMORY_LOADER_VERIFY_EN
    // Read-back verify: clean memory then a corrupted word 1.
    for (int pass = 0; pass < 2; pass++) begin
      flip = (pass == 1);
      exp_wr.push_back({13'd0, 32'h04030201, 4'hF});
      exp_wr.push_back({13'd1, 32'h08070605, 4'hF});
      exp_done.push_back({flip, 16'h0024});
      do_start(16'd8);
      for (int k = 1; k <= 8; k++) send(8'(k), 1'b0, 1'b0);
      end_stream();
      wait_done(6 + pass);
    end
    flip = 1'b0;
`endif

    // Reset after five bytes of an eight-byte image: only word 0 written.
    d0 = done_cnt;
    exp_wr.push_back({13'd0, 32'hDDCCBBAA, 4'hF});
    w0 = wr_cnt;
    do_start(16'd8);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0);
    send(8'hDD, 1'b0, 1'b0);
    send(8'hEE, 1'b0, 1'b0);
    @(negedge clk); reset_n = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_writes", wr_cnt - w0, 1);
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_no_more_writes", wr_cnt - w0, 1);
    check("midreset_no_done", done_cnt, d0);
    check("mem_word0", mem[0], 32'hDDCCBBAA);

    check("wr_queue_empty", exp_wr.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
